// File: rtl/tcam_lookup_sched.sv
// Front-end scheduler for the TCAM search pipeline.
// Round-robin arbitration of search keys, a fixed-latency tag line that steers
// results back to their requester, and a drain/grant handshake for table updates.
module tcam_lookup_sched #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned KWID   = 104,
  parameter int unsigned IDWID  = 8,
  parameter int unsigned LAT    = 7,
  parameter int unsigned MAXOUT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        i_req_valid,
  input  logic [NREQ*KWID-1:0]   i_req_key,
  output logic [NREQ-1:0]        o_req_ready,
  output logic                   o_srch_valid,
  output logic [KWID-1:0]        o_srch_key,
  input  logic                   i_res_valid,
  input  logic [IDWID-1:0]       i_res_ruleid,
  output logic [NREQ-1:0]        o_rsp_valid,
  output logic                   o_rsp_hit,
  output logic [IDWID-1:0]       o_rsp_ruleid,
  input  logic                   i_upd_req,
  output logic                   o_upd_gnt,
  output logic                   o_idle
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = $clog2(MAXOUT + 1);
  localparam logic [CW-1:0] OUT_MAX  = CW'(MAXOUT);
  localparam logic [IW-1:0] IDX_LAST = IW'(NREQ - 1);

  typedef enum logic [1:0] {StRun, StDrain, StUpd} state_e;

  state_e            r_state;
  state_e            w_state_d;
  logic              r_upd_gnt;
  logic [IW-1:0]     r_ptr;
  logic [CW-1:0]     r_outst [NREQ];

  logic              r_srch_valid;
  logic [KWID-1:0]   r_srch_key;
  logic [IW-1:0]     r_srch_idx;

  logic [LAT-1:0]    r_dl_vld;
  logic [IW-1:0]     r_dl_idx [LAT];

  logic              w_arb_en;
  logic              w_idle;
  logic              w_tail_vld;
  logic [NREQ-1:0]   w_elig;
  logic [NREQ-1:0]   w_gnt_oh;
  logic [IW-1:0]     w_gnt_idx;
  logic              w_gnt_any;
  logic [KWID-1:0]   w_gnt_key;
  logic [NREQ-1:0]   w_ret_oh;

  // Pipeline is empty once neither the issue register nor the tag line holds a search.
  assign w_idle     = ~(|r_dl_vld) & ~r_srch_valid;
  assign w_tail_vld = r_dl_vld[LAT-1];
  // A pending update request blocks grants even in the cycle it first appears.
  assign w_arb_en   = (r_state == StRun) & ~i_upd_req & ~rst;

  // Requester eligibility: key offered and in-flight budget not exhausted.
  always_comb begin
    w_elig = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      w_elig[i] = i_req_valid[i] & (r_outst[i] < OUT_MAX);
    end
  end

  // Round-robin pick: first eligible requester at or after the pointer.
  always_comb begin
    int unsigned v_idx;
    w_gnt_oh  = '0;
    w_gnt_idx = '0;
    w_gnt_any = 1'b0;
    w_gnt_key = '0;
    v_idx     = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      v_idx = 32'(r_ptr) + k;
      if (v_idx >= NREQ) v_idx = v_idx - NREQ;
      if (!w_gnt_any && w_arb_en && w_elig[v_idx[IW-1:0]]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = v_idx[IW-1:0];
      end
    end
    if (w_gnt_any) w_gnt_oh[w_gnt_idx] = 1'b1;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_gnt_oh[i]) w_gnt_key = i_req_key[i*KWID +: KWID];
    end
  end

  // Decode the returning tag into a one-hot requester strobe.
  always_comb begin
    w_ret_oh = '0;
    if (w_tail_vld) w_ret_oh[r_dl_idx[LAT-1]] = 1'b1;
  end

  // Issue register: accepted key is presented to the pipeline one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_srch_valid <= 1'b0;
      r_srch_key   <= '0;
      r_srch_idx   <= '0;
    end else begin
      r_srch_valid <= w_gnt_any;
      r_srch_idx   <= w_gnt_idx;
      if (w_gnt_any) r_srch_key <= w_gnt_key;
    end
  end

  // Tag line: tail lines up with the priority engine result for each issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dl_vld <= '0;
      for (int unsigned s = 0; s < LAT; s++) r_dl_idx[s] <= '0;
    end else begin
      r_dl_vld    <= {r_dl_vld[LAT-2:0], r_srch_valid};
      r_dl_idx[0] <= r_srch_idx;
      for (int unsigned s = 1; s < LAT; s++) r_dl_idx[s] <= r_dl_idx[s-1];
    end
  end

  // Per-requester in-flight counters; simultaneous grant and return cancel out.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREQ; i++) r_outst[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (w_gnt_oh[i] && !w_ret_oh[i]) begin
          r_outst[i] <= r_outst[i] + CW'(1);
        end else if (!w_gnt_oh[i] && w_ret_oh[i]) begin
          r_outst[i] <= r_outst[i] - CW'(1);
        end
      end
    end
  end

  // Round-robin pointer advances past the winner and holds otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_gnt_any) begin
      r_ptr <= (w_gnt_idx == IDX_LAST) ? '0 : w_gnt_idx + IW'(1);
    end
  end

  // Update handshake state register; grant flag tracks entry into StUpd.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= StRun;
      r_upd_gnt <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_upd_gnt <= (w_state_d == StUpd);
    end
  end

  // Update handshake next state: abort back to StRun whenever the request drops.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StRun:   if (i_upd_req) w_state_d = StDrain;
      StDrain: begin
        if (!i_upd_req)  w_state_d = StRun;
        else if (w_idle) w_state_d = StUpd;
      end
      StUpd:   if (!i_upd_req) w_state_d = StRun;
      default: w_state_d = StRun;
    endcase
  end

  // Outputs are forced to their reset values while rst is held.
  always_comb begin
    o_req_ready  = w_gnt_oh;
    o_srch_valid = r_srch_valid & ~rst;
    o_srch_key   = rst ? '0 : r_srch_key;
    o_rsp_valid  = rst ? '0 : w_ret_oh;
    o_rsp_hit    = 1'b0;
    o_rsp_ruleid = '0;
    if (w_tail_vld && !rst) begin
      o_rsp_hit    = i_res_valid;
      o_rsp_ruleid = i_res_valid ? i_res_ruleid : '0;
    end
    // Grant drops combinationally with the request so the updater sees release at once.
    o_upd_gnt    = r_upd_gnt & i_upd_req & ~rst;
    o_idle       = w_idle | rst;
  end

`ifndef SYNTHESIS
  // A result with no search at the tail means the pipeline latency is misconfigured.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(i_res_valid && !w_tail_vld))
        else $error("tcam_lookup_sched: result returned with no search in flight");
    end
  end
`endif

endmodule

// File: tb/tb_tcam_lookup_sched.sv
// Self-checking bench for tcam_lookup_sched: a cycle model predicts grants, issue,
// responses and the update handshake; expected responses queue up at grant time.
module tb_tcam_lookup_sched;

  localparam int NREQ   = 4;
  localparam int KWID   = 104;
  localparam int IDWID  = 8;
  localparam int LAT    = 7;
  localparam int MAXOUT = 4;

  logic                 clk;
  logic                 rst;
  logic [NREQ-1:0]      i_req_valid;
  logic [NREQ*KWID-1:0] i_req_key;
  logic [NREQ-1:0]      o_req_ready;
  logic                 o_srch_valid;
  logic [KWID-1:0]      o_srch_key;
  logic                 i_res_valid;
  logic [IDWID-1:0]     i_res_ruleid;
  logic [NREQ-1:0]      o_rsp_valid;
  logic                 o_rsp_hit;
  logic [IDWID-1:0]     o_rsp_ruleid;
  logic                 i_upd_req;
  logic                 o_upd_gnt;
  logic                 o_idle;

  tcam_lookup_sched #(
    .NREQ  (NREQ),
    .KWID  (KWID),
    .IDWID (IDWID),
    .LAT   (LAT),
    .MAXOUT(MAXOUT)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .i_req_valid (i_req_valid),
    .i_req_key   (i_req_key),
    .o_req_ready (o_req_ready),
    .o_srch_valid(o_srch_valid),
    .o_srch_key  (o_srch_key),
    .i_res_valid (i_res_valid),
    .i_res_ruleid(i_res_ruleid),
    .o_rsp_valid (o_rsp_valid),
    .o_rsp_hit   (o_rsp_hit),
    .o_rsp_ruleid(o_rsp_ruleid),
    .i_upd_req   (i_upd_req),
    .o_upd_gnt   (o_upd_gnt),
    .o_idle      (o_idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {MRun, MDrain, MUpd} mstate_e;
  typedef struct {
    int               due;
    int               idx;
    bit               hit;
    logic [IDWID-1:0] rid;
  } rsp_t;

  rsp_t             q[$];
  int               n_cmp = 0;
  int               n_err = 0;
  int               cyc = 0;
  int               m_ptr = 0;
  int               m_outst[NREQ];
  mstate_e          m_state = MRun;
  bit               exp_sv = 1'b0;
  logic [KWID-1:0]  exp_key = '0;
  bit               force_hit = 1'b0;
  logic [IDWID-1:0] force_rid = '0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
    end
  endtask

  // One clock: drive at posedge+1, check and advance the model at negedge.
  task automatic run_cycle(input logic [NREQ-1:0] vmask, input logic upd, input logic rst_v);
    logic [127:0]    rnd;
    int              g;
    int              c;
    logic [NREQ-1:0] exp_oh;
    logic [NREQ-1:0] exp_rv;
    bit              has_rsp;
    bit              exp_hit;
    logic [IDWID-1:0] exp_rid;
    bit              exp_idle;
    bit              nxt_sv;
    logic [KWID-1:0] nxt_key;
    rsp_t            r;

    rst         = rst_v;
    i_req_valid = vmask;
    i_upd_req   = upd;
    for (int i = 0; i < NREQ; i++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom};
      i_req_key[i*KWID +: KWID] = rnd[KWID-1:0];
    end
    has_rsp = 1'b0;
    if (!rst_v && q.size() > 0) has_rsp = (q[0].due == cyc);
    i_res_ruleid = IDWID'($urandom);
    if (rst_v) begin
      i_res_valid = 1'b1;  // late result arriving during reset must be dropped
    end else if (has_rsp) begin
      i_res_valid = q[0].hit;
      if (q[0].hit) i_res_ruleid = q[0].rid;
    end else begin
      i_res_valid = 1'b0;
    end

    @(negedge clk);
    if (rst_v) begin
      chk("rst_ready",   o_req_ready,  '0);
      chk("rst_srch",    o_srch_valid, 1'b0);
      chk("rst_rsp",     o_rsp_valid,  '0);
      chk("rst_upd_gnt", o_upd_gnt,    1'b0);
      chk("rst_idle",    o_idle,       1'b1);
      m_ptr   = 0;
      m_state = MRun;
      exp_sv  = 1'b0;
      q.delete();
      for (int i = 0; i < NREQ; i++) m_outst[i] = 0;
    end else begin
      g      = -1;
      exp_oh = '0;
      if (m_state == MRun && !upd) begin
        for (int k = 0; k < NREQ; k++) begin
          c = (m_ptr + k) % NREQ;
          if (g < 0 && vmask[c] && m_outst[c] < MAXOUT) g = c;
        end
      end
      if (g >= 0) exp_oh[g] = 1'b1;
      chk("ready", o_req_ready, exp_oh);

      chk("srch_valid", o_srch_valid, exp_sv);
      if (exp_sv) chk("srch_key", o_srch_key, exp_key);

      exp_rv  = '0;
      exp_hit = 1'b0;
      exp_rid = '0;
      if (has_rsp) begin
        exp_rv[q[0].idx] = 1'b1;
        exp_hit          = q[0].hit;
        exp_rid          = q[0].hit ? q[0].rid : '0;
      end
      chk("rsp_valid",  o_rsp_valid,  exp_rv);
      chk("rsp_hit",    o_rsp_hit,    exp_hit);
      chk("rsp_ruleid", o_rsp_ruleid, exp_rid);

      exp_idle = (q.size() == 0) || (q[0].due - LAT > cyc);
      chk("idle",    o_idle,    exp_idle);
      chk("upd_gnt", o_upd_gnt, (m_state == MUpd) && upd);

      if (has_rsp) begin
        m_outst[q[0].idx]--;
        void'(q.pop_front());
      end
      nxt_sv  = 1'b0;
      nxt_key = exp_key;
      if (g >= 0) begin
        r.due = cyc + 1 + LAT;
        r.idx = g;
        r.hit = force_hit || ($urandom_range(0, 3) != 0);
        r.rid = force_hit ? force_rid : IDWID'($urandom);
        q.push_back(r);
        m_outst[g]++;
        m_ptr   = (g + 1) % NREQ;
        nxt_sv  = 1'b1;
        nxt_key = i_req_key[g*KWID +: KWID];
      end
      case (m_state)
        MRun:   if (upd) m_state = MDrain;
        MDrain: begin
          if (!upd)          m_state = MRun;
          else if (exp_idle) m_state = MUpd;
        end
        default: if (!upd) m_state = MRun;
      endcase
      exp_sv  = nxt_sv;
      exp_key = nxt_key;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  logic upd_r;

  initial begin
    rst          = 1'b1;
    i_req_valid  = '0;
    i_req_key    = '0;
    i_res_valid  = 1'b0;
    i_res_ruleid = '0;
    i_upd_req    = 1'b0;
    for (int i = 0; i < NREQ; i++) m_outst[i] = 0;
    @(posedge clk);
    #1;
    repeat (2) run_cycle('0, 1'b0, 1'b1);

    // Single lookup from requester 0 returning a hit on rule 0x2A.
    force_hit = 1'b1;
    force_rid = 8'h2A;
    run_cycle(4'b0001, 1'b0, 1'b0);
    force_hit = 1'b0;
    repeat (12) run_cycle('0, 1'b0, 1'b0);

    // All requesters continuously: rotation, then the in-flight cap throttles.
    repeat (30) run_cycle(4'b1111, 1'b0, 1'b0);
    repeat (12) run_cycle('0, 1'b0, 1'b0);

    // Requester 2 alone: cap of MAXOUT, then one grant per returning response.
    repeat (30) run_cycle(4'b0100, 1'b0, 1'b0);
    repeat (12) run_cycle('0, 1'b0, 1'b0);

    // Update drain with searches in flight, then release.
    repeat (3)  run_cycle(4'b1111, 1'b0, 1'b0);
    repeat (15) run_cycle(4'b1111, 1'b1, 1'b0);
    repeat (5)  run_cycle(4'b1111, 1'b0, 1'b0);
    repeat (12) run_cycle('0, 1'b0, 1'b0);

    // Aborted update: short request pulse during drain.
    repeat (3)  run_cycle(4'b1111, 1'b0, 1'b0);
    repeat (2)  run_cycle(4'b1111, 1'b1, 1'b0);
    repeat (4)  run_cycle(4'b1111, 1'b0, 1'b0);
    repeat (12) run_cycle('0, 1'b0, 1'b0);

    // Reset with searches in flight: nothing may come back afterwards.
    repeat (5)  run_cycle(4'b1111, 1'b0, 1'b0);
    run_cycle(4'b1111, 1'b0, 1'b1);
    repeat (12) run_cycle('0, 1'b0, 1'b0);
    repeat (6)  run_cycle(4'b0001, 1'b0, 1'b0);
    repeat (12) run_cycle('0, 1'b0, 1'b0);

    // Random traffic with occasional update requests.
    upd_r = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 19) == 0) upd_r = ~upd_r;
      run_cycle(NREQ'($urandom), upd_r, 1'b0);
    end
    repeat (15) run_cycle('0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
